// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: ram read port plus redirect and the decode handshake.
interface fetch_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] mem_rd_addr;
    logic [WIDTH-1:0]     mem_data_in;
    logic                 redirect_valid;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [WIDTH-1:0]     instr_data;
    logic [WORD_SIZE-1:0] instr_pc;

    modport master (
        output mem_rd_addr, instr_valid, instr_data, instr_pc,
        input  mem_data_in, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_rd_addr, instr_valid, instr_data, instr_pc,
        output mem_data_in, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential reads from a 1-cycle synchronous ram into a small
// prefetch FIFO of {pc, word}, drained by decode; redirect flushes the stream.
module fetch_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [WORD_SIZE-1:0] RST_PC = WORD_SIZE'(RESET_PC);

    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] inflight_pc;
    logic                 inflight;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;
    logic [CW:0]          occupancy;
    logic                 head_valid;
    logic                 issue;
    logic                 push;
    logic                 pop;

    logic [WIDTH-1:0]     data_q [DEPTH];
    logic [WORD_SIZE-1:0] pc_q   [DEPTH];

    // Outstanding read reserves a slot so its response can never overflow the FIFO.
    always_comb begin
        head_valid = (count != '0);
        occupancy  = {1'b0, count} + (CW + 1)'(inflight);
        issue      = !bus.redirect_valid && (occupancy < (CW + 1)'(DEPTH));
        push       = inflight && !bus.redirect_valid;
        pop        = head_valid && bus.instr_ready && !bus.redirect_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RST_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= bus.mem_data_in;
            pc_q[wr_ptr]   <= inflight_pc;
        end
    end

    assign bus.mem_rd_addr = fetch_pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr_data  = head_valid ? data_q[rd_ptr] : '0;
    assign bus.instr_pc    = head_valid ? pc_q[rd_ptr]   : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scripted vector table, multi-cycle corner sequences, and a
// randomized run checked against a stream-level reference (two address widths).
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.WIDTH(32), .WORD_SIZE(8)) bus0 ();
    fetch_if #(.WIDTH(32), .WORD_SIZE(3)) bus1 ();

    fetch_unit #(.WIDTH(32), .WORD_SIZE(8), .DEPTH(4), .RESET_PC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    fetch_unit #(.WIDTH(32), .WORD_SIZE(3), .DEPTH(4), .RESET_PC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic int ref_data(input int inst, input int pc);
        return (inst == 0) ? 11 * (pc + 1) : 1000 + 7 * pc;
    endfunction

    logic [31:0] ram0 [256];
    logic [31:0] ram1 [8];
    always @(posedge clk) begin
        bus0.mem_data_in <= ram0[bus0.mem_rd_addr];
        bus1.mem_data_in <= ram1[bus1.mem_rd_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rdy, input bit rv, input int rpc);
        bus0.instr_ready    = rdy;
        bus0.redirect_valid = rv;
        bus0.redirect_pc    = 8'(rpc);
        bus1.instr_ready    = rdy;
        bus1.redirect_valid = rv;
        bus1.redirect_pc    = 3'(rpc);
    endtask

    // Stream-level reference: accepted words form runs of consecutive pcs starting
    // at reset pc or a redirect target; head holds while stalled; redirect latency 3.
    int  exp_pc [2];
    bit  hold   [2];
    int  hpc    [2];
    int  hdata  [2];
    int  age    [2];
    int  rtgt   [2];
    int  last1;
    bit  wrap_seen;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_pc[i] = 0; hold[i] = 0; hpc[i] = 0; hdata[i] = 0; age[i] = 0; rtgt[i] = 0;
        end
        last1 = -1;
    endtask

    task automatic model(input int i, input bit v, input int pc, input int data,
                         input bit rdy, input bit rv, input int rpc);
        int mask;
        mask = (i == 0) ? 255 : 7;
        if (hold[i]) begin
            chk("hold_valid", int'(v), 1);
            chk("hold_pc", pc, hpc[i]);
            chk("hold_data", data, hdata[i]);
        end
        if (age[i] == 1 || age[i] == 2) chk("redir_gap_valid", int'(v), 0);
        if (age[i] == 3) begin
            chk("redir_lat_valid", int'(v), 1);
            chk("redir_lat_pc", pc, rtgt[i]);
        end
        if (v && rdy && !rv) begin
            chk("stream_pc", pc, exp_pc[i]);
            chk("stream_data", data, ref_data(i, exp_pc[i]));
            if (i == 1 && last1 == 7 && pc == 0) wrap_seen = 1'b1;
            if (i == 1) last1 = pc;
            exp_pc[i] = (exp_pc[i] + 1) & mask;
        end
        hold[i]  = v && !rdy && !rv;
        hpc[i]   = pc;
        hdata[i] = data;
        if (rv) begin
            exp_pc[i] = rpc & mask;
            rtgt[i]   = rpc & mask;
            age[i]    = 1;
        end else if (age[i] != 0) begin
            age[i] = (age[i] >= 3) ? 0 : age[i] + 1;
        end
    endtask

    task automatic step_model(input bit rdy, input bit rv, input int rpc);
        bit v0, v1;
        int p0, p1, d0, d1;
        v0 = bus0.instr_valid; p0 = int'(bus0.instr_pc); d0 = int'(bus0.instr_data);
        v1 = bus1.instr_valid; p1 = int'(bus1.instr_pc); d1 = int'(bus1.instr_data);
        drive(rdy, rv, rpc);
        model(0, v0, p0, d0, rdy, rv, rpc);
        model(1, v1, p1, d1, rdy, rv, rpc);
    endtask

    // Ends on the negedge where rst_n is released (cycle 0 of the new stream).
    task automatic do_reset(input bit rdy);
        rst_n = 1'b0;
        drive(rdy, 1'b0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit rdy; bit rv; int rpc;
        bit ev;  int epc; int edata; int eaddr;
    } vec_t;
    vec_t tbl [23];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        for (int i = 0; i < 256; i++) ram0[i] = 32'(ref_data(0, i));
        for (int i = 0; i < 8; i++)   ram1[i] = 32'(ref_data(1, i));
        wrap_seen = 1'b0;

        //          rdy rv rpc  ev epc edata eaddr
        tbl[0]  = '{1, 0, 0,   0, 0,  0,   0};
        tbl[1]  = '{1, 0, 0,   0, 0,  0,   1};
        tbl[2]  = '{1, 0, 0,   1, 0,  11,  2};
        tbl[3]  = '{1, 0, 0,   1, 1,  22,  3};
        tbl[4]  = '{1, 0, 0,   1, 2,  33,  4};
        tbl[5]  = '{1, 1, 20,  1, 3,  44,  5};
        tbl[6]  = '{1, 0, 0,   0, 0,  0,   20};
        tbl[7]  = '{1, 0, 0,   0, 0,  0,   21};
        tbl[8]  = '{1, 0, 0,   1, 20, 231, 22};
        tbl[9]  = '{0, 0, 0,   1, 21, 242, 23};
        tbl[10] = '{0, 0, 0,   1, 21, 242, 24};
        tbl[11] = '{0, 0, 0,   1, 21, 242, 25};
        tbl[12] = '{0, 0, 0,   1, 21, 242, 25};
        tbl[13] = '{1, 0, 0,   1, 21, 242, 25};
        tbl[14] = '{1, 0, 0,   1, 22, 253, 25};
        tbl[15] = '{1, 0, 0,   1, 23, 264, 26};
        tbl[16] = '{1, 0, 0,   1, 24, 275, 27};
        tbl[17] = '{1, 1, 250, 1, 25, 286, 28};
        tbl[18] = '{0, 1, 3,   0, 0,  0,   250};
        tbl[19] = '{1, 0, 0,   0, 0,  0,   3};
        tbl[20] = '{1, 0, 0,   0, 0,  0,   4};
        tbl[21] = '{1, 0, 0,   1, 3,  44,  5};
        tbl[22] = '{1, 0, 0,   1, 4,  55,  6};

        do_reset(1'b1);
        for (int k = 0; k < 23; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), int'(bus0.instr_valid), int'(tbl[k].ev));
            chk($sformatf("tbl%0d_pc", k),    int'(bus0.instr_pc),    tbl[k].epc);
            chk($sformatf("tbl%0d_data", k),  int'(bus0.instr_data),  tbl[k].edata);
            chk($sformatf("tbl%0d_addr", k),  int'(bus0.mem_rd_addr), tbl[k].eaddr);
            drive(tbl[k].rdy, tbl[k].rv, tbl[k].rpc);
        end

        // Stall until full, then drain: pcs 0..7 in order, none lost or repeated.
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        chk("full_addr", int'(bus0.mem_rd_addr), 4);
        chk("full_valid", int'(bus0.instr_valid), 1);
        chk("full_head_pc", int'(bus0.instr_pc), 0);
        chk("full_head_data", int'(bus0.instr_data), 11);
        drive(1'b1, 1'b0, 0);
        got = 1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if (bus0.instr_valid) begin
                chk("drain_pc", int'(bus0.instr_pc), got);
                chk("drain_data", int'(bus0.instr_data), ref_data(0, got));
                got++;
            end
        end
        chk("drain_count", got, 8);

        // Redirect to 5 while pcs 2,3 are buffered.
        do_reset(1'b0);
        repeat (10) @(negedge clk);
        drive(1'b1, 1'b0, 0);
        @(negedge clk);
        chk("rd_pre_pc1", int'(bus0.instr_pc), 1);
        @(negedge clk);
        chk("rd_head_pc2", int'(bus0.instr_pc), 2);
        drive(1'b0, 1'b1, 5);
        @(negedge clk);
        chk("rd_r1_valid", int'(bus0.instr_valid), 0);
        drive(1'b1, 1'b0, 0);
        @(negedge clk);
        chk("rd_r2_valid", int'(bus0.instr_valid), 0);
        @(negedge clk);
        chk("rd_r3_valid", int'(bus0.instr_valid), 1);
        chk("rd_r3_pc", int'(bus0.instr_pc), 5);
        chk("rd_r3_data", int'(bus0.instr_data), 66);

        // Asynchronous reset between edges, then a clean restart.
        do_reset(1'b1);
        repeat (6) @(negedge clk);
        chk("ar_pre_pc", int'(bus0.instr_pc), 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(bus0.instr_valid), 0);
        chk("ar_pc", int'(bus0.instr_pc), 0);
        chk("ar_data", int'(bus0.instr_data), 0);
        chk("ar_addr", int'(bus0.mem_rd_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_c1_valid", int'(bus0.instr_valid), 0);
        @(negedge clk);
        chk("ar_c2_valid", int'(bus0.instr_valid), 1);
        chk("ar_c2_pc", int'(bus0.instr_pc), 0);
        chk("ar_c2_data", int'(bus0.instr_data), 11);
        @(negedge clk);
        chk("ar_c3_pc", int'(bus0.instr_pc), 1);
        chk("ar_c3_data", int'(bus0.instr_data), 22);

        // Free run: the 3-bit instance must wrap 7 -> 0.
        do_reset(1'b1);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            step_model(1'b1, 1'b0, 0);
        end
        chk("wrap_seen", int'(wrap_seen), 1);

        // Randomized stalls and redirects.
        for (int c = 0; c < 3000; c++) begin
            bit rdy, rv;
            int rpc;
            @(negedge clk);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = int'($urandom_range(0, 255));
            step_model(rdy, rv, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
